// File: rtl/eeprom_page_ctrl_if.sv
// Signal bundle between eeprom_page_ctrl and its neighbours.
// The slave modport is the controller side; the master modport is the user/iic_drive side.
`timescale 1ns/1ps
interface eeprom_page_ctrl_if #(
  parameter int P_ADDR_WIDTH = 16,
  parameter int P_LEN_WIDTH  = 10
);
  logic [2:0]              i_eeprom_addr;
  logic [P_ADDR_WIDTH-1:0] i_user_operation_addr;
  logic [1:0]              i_user_operation_type;
  logic [P_LEN_WIDTH-1:0]  i_user_operation_len;
  logic                    i_user_operation_valid;
  logic                    o_user_operation_ready;
  logic [7:0]              i_user_write_date;
  logic                    i_user_write_valid;
  logic                    i_user_write_sop;
  logic                    i_user_write_eop;
  logic [7:0]              o_user_read_date;
  logic                    o_user_read_valid;
  logic                    o_overflow;
  logic [6:0]              o_device_addr;
  logic [15:0]             o_operation_addr;
  logic [7:0]              o_operation_len;
  logic [1:0]              o_operation_type;
  logic                    o_operation_valid;
  logic                    i_operation_ready;
  logic [7:0]              o_write_date;
  logic                    i_write_req;
  logic [7:0]              i_read_date;
  logic                    i_read_valid;

  modport slave (
    input  i_eeprom_addr, i_user_operation_addr, i_user_operation_type, i_user_operation_len,
    input  i_user_operation_valid, i_user_write_date, i_user_write_valid, i_user_write_sop,
    input  i_user_write_eop, i_operation_ready, i_write_req, i_read_date, i_read_valid,
    output o_user_operation_ready, o_user_read_date, o_user_read_valid, o_overflow,
    output o_device_addr, o_operation_addr, o_operation_len, o_operation_type,
    output o_operation_valid, o_write_date
  );

  modport master (
    output i_eeprom_addr, i_user_operation_addr, i_user_operation_type, i_user_operation_len,
    output i_user_operation_valid, i_user_write_date, i_user_write_valid, i_user_write_sop,
    output i_user_write_eop, i_operation_ready, i_write_req, i_read_date, i_read_valid,
    input  o_user_operation_ready, o_user_read_date, o_user_read_valid, o_overflow,
    input  o_device_addr, o_operation_addr, o_operation_len, o_operation_type,
    input  o_operation_valid, o_write_date
  );
endinterface

// File: rtl/eeprom_page_ctrl.sv
// EEPROM transaction controller: buffers write bursts, splits them on page/read-chunk boundaries,
// and waits the write-cycle time between page programs. Optional o_wp output with EEPROM_WP_EN.
`timescale 1ns/1ps
module eeprom_page_ctrl #(
  parameter int P_ADDR_WIDTH = 16,
  parameter int P_PAGE_SIZE  = 32,
  parameter int P_LEN_WIDTH  = 10,
  parameter int P_BUF_DEPTH  = 1024,
  parameter int P_MAX_RD     = 128,
  parameter int P_TWR_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rst,
`ifdef EEPROM_WP_EN
  output logic o_wp,
`endif
  eeprom_page_ctrl_if.slave bus
);

  localparam int PTR_W = $clog2(P_BUF_DEPTH);
  localparam int TW    = (P_TWR_CYCLES > 1) ? $clog2(P_TWR_CYCLES) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_DATA = 3'd1;
  localparam logic [2:0] S_ISSUE     = 3'd2;
  localparam logic [2:0] S_WAIT_BUSY = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_TWR       = 3'd5;

  logic [7:0]              mem_q [P_BUF_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_idx;
  logic [PTR_W:0]          count_q, count_d;
  logic                    push;
  logic                    eop_seen_q, eop_seen_d;
  logic                    overflow_q, overflow_d;
  logic [7:0]              write_date_q, write_date_d;
  logic [7:0]              read_date_q;
  logic                    read_valid_q;

  logic [2:0]              state_q, state_d;
  logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [P_LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [1:0]              type_q, type_d;
  logic [2:0]              chip_q, chip_d;
  logic                    nop_q, nop_d;
  logic [TW-1:0]           twr_cnt_q, twr_cnt_d;
  logic                    write_done;
  logic                    user_ready;
  logic                    is_write;
  logic                    in_issue;
  logic [31:0]             page_room, top_room, lim;
  logic [7:0]              chunk;

  assign is_write   = (type_q == 2'd1);
  assign in_issue   = (state_q == S_ISSUE);
  assign user_ready = (state_q == S_IDLE) && !nop_q;

  // Chunk is derived from the live address/remaining count; both stay frozen from ISSUE to WAIT_DONE.
  always_comb begin
    page_room = 32'(P_PAGE_SIZE) - (32'(addr_q) & 32'(P_PAGE_SIZE - 1));
    top_room  = (32'd1 << P_ADDR_WIDTH) - 32'(addr_q);
    lim       = is_write ? page_room : 32'(P_MAX_RD);
    if (top_room < lim) lim = top_room;
    if (32'(rem_q) < lim) lim = 32'(rem_q);
    chunk = 8'(lim);
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    wr_idx       = wr_ptr_q;
    push         = 1'b0;
    overflow_d   = 1'b0;
    write_date_d = write_date_q;
    eop_seen_d   = eop_seen_q;
    if (write_done) eop_seen_d = 1'b0;
    if (bus.i_write_req) begin
      if (count_q != '0) begin
        write_date_d = mem_q[rd_ptr_q];
        rd_ptr_d     = rd_ptr_q + PTR_W'(1);
        count_d      = count_q - (PTR_W+1)'(1);
      end else begin
        write_date_d = 8'h00;
      end
    end
    // A sop byte restarts the buffer so any surplus from the previous burst is discarded.
    if (bus.i_user_write_valid) begin
      if (bus.i_user_write_eop) eop_seen_d = 1'b1;
      if (bus.i_user_write_sop) begin
        push     = 1'b1;
        wr_idx   = '0;
        wr_ptr_d = PTR_W'(1);
        rd_ptr_d = '0;
        count_d  = (PTR_W+1)'(1);
      end else if (count_q == (PTR_W+1)'(P_BUF_DEPTH)) begin
        overflow_d = 1'b1;
      end else begin
        push     = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        count_d  = count_d + (PTR_W+1)'(1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    type_d     = type_q;
    chip_d     = chip_q;
    nop_d      = 1'b0;
    twr_cnt_d  = twr_cnt_q;
    write_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_user_operation_valid && user_ready) begin
          addr_d = bus.i_user_operation_addr;
          rem_d  = bus.i_user_operation_len;
          type_d = bus.i_user_operation_type;
          chip_d = bus.i_eeprom_addr;
          if (bus.i_user_operation_len == '0)        nop_d   = 1'b1;
          else if (bus.i_user_operation_type == 2'd1) state_d = S_WAIT_DATA;
          else if (bus.i_user_operation_type == 2'd2) state_d = S_ISSUE;
          else                                         nop_d   = 1'b1;
        end
      end
      S_WAIT_DATA: if (eop_seen_q) state_d = S_ISSUE;
      S_ISSUE:     if (bus.i_operation_ready) state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!bus.i_operation_ready) state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (bus.i_operation_ready) begin
          addr_d = addr_q + P_ADDR_WIDTH'(chunk);
          rem_d  = rem_q - P_LEN_WIDTH'(chunk);
          if (is_write) begin
            state_d   = S_TWR;
            twr_cnt_d = '0;
          end else if (rem_q == P_LEN_WIDTH'(chunk)) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_TWR: begin
        if (twr_cnt_q == TW'(P_TWR_CYCLES - 1)) begin
          if (rem_q != '0) begin
            state_d = S_ISSUE;
          end else begin
            state_d    = S_IDLE;
            write_done = 1'b1;
          end
        end else begin
          twr_cnt_d = twr_cnt_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_idx] <= bus.i_user_write_date;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      eop_seen_q   <= 1'b0;
      overflow_q   <= 1'b0;
      write_date_q <= '0;
      read_date_q  <= '0;
      read_valid_q <= 1'b0;
      state_q      <= S_IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      type_q       <= '0;
      chip_q       <= '0;
      nop_q        <= 1'b0;
      twr_cnt_q    <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      eop_seen_q   <= eop_seen_d;
      overflow_q   <= overflow_d;
      write_date_q <= write_date_d;
      read_date_q  <= bus.i_read_date;
      read_valid_q <= bus.i_read_valid;
      state_q      <= state_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      type_q       <= type_d;
      chip_q       <= chip_d;
      nop_q        <= nop_d;
      twr_cnt_q    <= twr_cnt_d;
    end
  end

  // Command fields are only presented while a chunk is being offered, so idle outputs read as zero.
  assign bus.o_user_operation_ready = user_ready;
  assign bus.o_operation_valid      = in_issue;
  assign bus.o_operation_addr       = in_issue ? 16'(addr_q) : 16'h0000;
  assign bus.o_operation_len        = in_issue ? chunk : 8'h00;
  assign bus.o_operation_type       = in_issue ? type_q : 2'd0;
  assign bus.o_device_addr          = in_issue ? {4'b1010, chip_q} : 7'h00;
  assign bus.o_write_date           = write_date_q;
  assign bus.o_overflow             = overflow_q;
  assign bus.o_user_read_date       = read_date_q;
  assign bus.o_user_read_valid      = read_valid_q;

`ifdef EEPROM_WP_EN
  assign o_wp = !(is_write && (state_q == S_ISSUE || state_q == S_WAIT_BUSY ||
                               state_q == S_WAIT_DONE || state_q == S_TWR));
`endif

endmodule

// File: tb/tb_eeprom_page_ctrl.sv
// Testbench for eeprom_page_ctrl with an iic_drive behavioural model and a queue-based reference model.
`timescale 1ns/1ps
module tb_eeprom_page_ctrl;
  localparam int AW = 16, PAGE = 32, LW = 10, DEPTH = 1024, MAXRD = 128, TWR = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  eeprom_page_ctrl_if #(.P_ADDR_WIDTH(AW), .P_LEN_WIDTH(LW)) bus();
`ifdef EEPROM_WP_EN
  logic wp;
`endif

  eeprom_page_ctrl #(
    .P_ADDR_WIDTH(AW), .P_PAGE_SIZE(PAGE), .P_LEN_WIDTH(LW),
    .P_BUF_DEPTH(DEPTH), .P_MAX_RD(MAXRD), .P_TWR_CYCLES(TWR)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
`ifdef EEPROM_WP_EN
    .o_wp(wp),
`endif
    .bus(bus)
  );

  typedef struct {
    logic [15:0] addr;
    int          len;
    logic [1:0]  typ;
    logic [6:0]  dev;
    int          gap;
  } op_t;

  typedef struct {
    logic [1:0]  op_type;
    logic [15:0] addr;
    int          len;
    int          nbytes;
    int          exp_nops;
    int          exp_first_len;
    logic [15:0] exp_last_addr;
    int          exp_last_len;
  } vec_t;

  op_t        got_ops[$], exp_ops[$];
  logic [7:0] got_wr[$], exp_wr[$], model_buf[$], rd_sent[$], rd_got[$];
  int checks = 0, failures = 0;
  int ovf_seen = 0, exp_ovf = 0, last_done = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.o_user_read_valid) rd_got.push_back(bus.o_user_read_date);
    if (bus.o_overflow) ovf_seen++;
  end

  // iic_drive model: accepts an op, holds ready low at least 20 cycles, moves the bytes.
  initial begin
    bus.i_operation_ready = 1'b1;
    bus.i_write_req       = 1'b0;
    bus.i_read_valid      = 1'b0;
    bus.i_read_date       = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst && bus.o_operation_valid && bus.i_operation_ready) begin
        op_t op;
        int  busy;
        op.addr = bus.o_operation_addr;
        op.len  = int'(bus.o_operation_len);
        op.typ  = bus.o_operation_type;
        op.dev  = bus.o_device_addr;
        op.gap  = cyc - last_done;
`ifdef EEPROM_WP_EN
        check_output("wp_during_op", {31'd0, wp}, (op.typ == 2'd1) ? 32'd0 : 32'd1);
`endif
        got_ops.push_back(op);
        @(negedge clk);
        bus.i_operation_ready = 1'b0;
        busy = 0;
        if (op.typ == 2'd1) begin
          for (int i = 0; i < op.len && !rst; i++) begin
            bus.i_write_req = 1'b1;
            @(negedge clk);
            busy++;
            got_wr.push_back(bus.o_write_date);
          end
          bus.i_write_req = 1'b0;
        end else begin
          for (int i = 0; i < op.len && !rst; i++) begin
            bus.i_read_valid = 1'b1;
            bus.i_read_date  = 8'($urandom);
            rd_sent.push_back(bus.i_read_date);
            @(negedge clk);
            busy++;
          end
          bus.i_read_valid = 1'b0;
        end
        while (busy < 20 && !rst) begin
          @(negedge clk);
          busy++;
        end
        bus.i_operation_ready = 1'b1;
        last_done = cyc;
      end
    end
  end

  task automatic stream_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      bus.i_user_write_valid = 1'b1;
      bus.i_user_write_date  = 8'($urandom);
      bus.i_user_write_sop   = (i == 0);
      bus.i_user_write_eop   = (i == n - 1);
      if (i == 0) model_buf.delete();
      if (model_buf.size() < DEPTH) model_buf.push_back(bus.i_user_write_date);
      else exp_ovf++;
      @(negedge clk);
    end
    bus.i_user_write_valid = 1'b0;
    bus.i_user_write_sop   = 1'b0;
    bus.i_user_write_eop   = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [1:0] t, input logic [15:0] a, input int len,
                                input logic [2:0] chip);
    int  ad, rem, lim, c, waited, mism;
    op_t e;
    got_ops.delete(); got_wr.delete(); rd_got.delete(); rd_sent.delete();
    exp_ops.delete(); exp_wr.delete();
    ad  = int'(a);
    rem = ((t == 2'd1) || (t == 2'd2)) ? len : 0;
    while (rem > 0) begin
      lim = (t == 2'd1) ? PAGE - (ad % PAGE) : MAXRD;
      if (65536 - ad < lim) lim = 65536 - ad;
      c = (rem < lim) ? rem : lim;
      e.addr = 16'(ad); e.len = c; e.typ = t; e.dev = {4'b1010, chip};
      e.gap  = (t == 2'd1) ? TWR + 1 : 1;
      exp_ops.push_back(e);
      ad  = (ad + c) % 65536;
      rem = rem - c;
    end
    if (t == 2'd1) begin
      for (int i = 0; i < len; i++) begin
        if (model_buf.size() > 0) exp_wr.push_back(model_buf.pop_front());
        else exp_wr.push_back(8'h00);
      end
    end
    bus.i_user_operation_type  = t;
    bus.i_user_operation_addr  = a;
    bus.i_user_operation_len   = LW'(len);
    bus.i_eeprom_addr          = chip;
    bus.i_user_operation_valid = 1'b1;
    @(negedge clk);
    bus.i_user_operation_valid = 1'b0;
    check_output("ready_drop", {31'd0, bus.o_user_operation_ready}, 0);
    waited = 0;
    while (!bus.o_user_operation_ready && waited < 20000) begin
      @(negedge clk);
      waited++;
    end
    check_output("cmd_done", {31'd0, bus.o_user_operation_ready}, 1);
    if (exp_ops.size() == 0) check_output("nop_ready_cycles", waited, 1);
    repeat (2) @(negedge clk);
    check_output("op_count", got_ops.size(), exp_ops.size());
    for (int i = 0; i < exp_ops.size() && i < got_ops.size(); i++) begin
      check_output("op_addr", got_ops[i].addr, exp_ops[i].addr);
      check_output("op_len",  got_ops[i].len,  exp_ops[i].len);
      check_output("op_type", got_ops[i].typ,  exp_ops[i].typ);
      check_output("op_dev",  got_ops[i].dev,  exp_ops[i].dev);
      if (i > 0) check_output("op_gap", got_ops[i].gap, exp_ops[i].gap);
    end
    if (t == 2'd1 && len > 0) begin
      check_output("wr_byte_count", got_wr.size(), exp_wr.size());
      mism = 0;
      for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
        if (got_wr[i] !== exp_wr[i]) mism++;
      check_output("wr_bytes", mism, 0);
    end
    if (t == 2'd2 && len > 0) begin
      check_output("rd_count", rd_got.size(), len);
      mism = 0;
      for (int i = 0; i < rd_sent.size() && i < rd_got.size(); i++)
        if (rd_got[i] !== rd_sent[i]) mism++;
      check_output("rd_bytes", mism, 0);
    end
  endtask

  task automatic check_reset_outputs();
    check_output("rst_ready",      {31'd0, bus.o_user_operation_ready}, 1);
    check_output("rst_op_valid",   {31'd0, bus.o_operation_valid}, 0);
    check_output("rst_op_addr",    {16'd0, bus.o_operation_addr}, 0);
    check_output("rst_op_len",     {24'd0, bus.o_operation_len}, 0);
    check_output("rst_dev",        {25'd0, bus.o_device_addr}, 0);
    check_output("rst_user_rv",    {31'd0, bus.o_user_read_valid}, 0);
    check_output("rst_write_date", {24'd0, bus.o_write_date}, 0);
    check_output("rst_overflow",   {31'd0, bus.o_overflow}, 0);
`ifdef EEPROM_WP_EN
    check_output("rst_wp", {31'd0, wp}, 1);
`endif
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[7];
    int   waited;
    vecs[0] = '{2'd1, 16'h001C, 10,  10, 2, 4,   16'h0020, 6};
    vecs[1] = '{2'd2, 16'h0100, 300, 0,  3, 128, 16'h0200, 44};
    vecs[2] = '{2'd1, 16'hFFFE, 4,   4,  2, 2,   16'h0000, 2};
    vecs[3] = '{2'd1, 16'h0040, 8,   5,  1, 8,   16'h0040, 8};
    vecs[4] = '{2'd1, 16'h0003, 3,   6,  1, 3,   16'h0003, 3};
    vecs[5] = '{2'd2, 16'hFFF0, 40,  0,  2, 16,  16'h0000, 24};
    vecs[6] = '{2'd2, 16'h0005, 1,   0,  1, 1,   16'h0005, 1};

    bus.i_eeprom_addr          = 3'd0;
    bus.i_user_operation_addr  = '0;
    bus.i_user_operation_type  = 2'd0;
    bus.i_user_operation_len   = '0;
    bus.i_user_operation_valid = 1'b0;
    bus.i_user_write_date      = 8'h00;
    bus.i_user_write_valid     = 1'b0;
    bus.i_user_write_sop       = 1'b0;
    bus.i_user_write_eop       = 1'b0;
    #2;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].nbytes > 0) stream_bytes(vecs[v].nbytes);
      apply_stimulus(vecs[v].op_type, vecs[v].addr, vecs[v].len, 3'(v));
      check_output("vec_nops", got_ops.size(), vecs[v].exp_nops);
      if (got_ops.size() > 0) begin
        check_output("vec_first_len", got_ops[0].len, vecs[v].exp_first_len);
        check_output("vec_last_addr", got_ops[got_ops.size()-1].addr, vecs[v].exp_last_addr);
        check_output("vec_last_len",  got_ops[got_ops.size()-1].len,  vecs[v].exp_last_len);
      end
    end

    apply_stimulus(2'd0, 16'h0010, 5, 3'd1);
    apply_stimulus(2'd3, 16'h0010, 5, 3'd1);
    apply_stimulus(2'd1, 16'h0010, 0, 3'd1);
    apply_stimulus(2'd2, 16'h0010, 0, 3'd1);

    for (int r = 0; r < 8; r++) begin
      logic [1:0] t;
      int         len;
      t   = 2'($urandom_range(1, 2));
      len = $urandom_range(1, 70);
      if (t == 2'd1) stream_bytes($urandom_range(1, len + 4));
      apply_stimulus(t, 16'($urandom), len, 3'($urandom));
    end

    ovf_seen = 0;
    exp_ovf  = 0;
    stream_bytes(1030);
    repeat (3) @(negedge clk);
    check_output("overflow_pulses", ovf_seen, 6);
    check_output("overflow_model", ovf_seen, exp_ovf);
    apply_stimulus(2'd1, 16'h0000, 1023, 3'd7);

    bus.i_user_operation_type  = 2'd2;
    bus.i_user_operation_addr  = 16'h0000;
    bus.i_user_operation_len   = LW'(100);
    bus.i_user_operation_valid = 1'b1;
    @(negedge clk);
    bus.i_user_operation_valid = 1'b0;
    waited = 0;
    while (bus.i_operation_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check_output("busy_seen", {31'd0, bus.i_operation_ready}, 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    waited = 0;
    while (!bus.i_operation_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    repeat (2) @(negedge clk);
    model_buf.delete();
    apply_stimulus(2'd2, 16'h0005, 1, 3'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
